// File: rtl/mat_stream_port_pkg.sv
// Shared state type and default sizing for the matrix stream port.
package mat_stream_port_pkg;

    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned AW_DEF    = 5;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StLoad   = 3'd1;
    localparam state_t StKick   = 3'd2;
    localparam state_t StWait   = 3'd3;
    localparam state_t StUnload = 3'd4;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output FIFO; head is presented combinationally, occupancy feeds read credit.
module stream_skid_fifo
    import mat_stream_port_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic [1:0]    occupancy
);

    logic [DW-1:0] entry0_q, entry1_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop && valid;
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr_q) entry1_q <= push_data;
                else          entry0_q <= push_data;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid     = (count_q != 2'd0);
    assign head      = rd_ptr_q ? entry1_q : entry0_q;
    assign occupancy = count_q;

endmodule

// File: rtl/mat_stream_port.sv
// Streams a DEPTH-word matrix into memory, kicks the systemizer, and streams memory back out.
module mat_stream_port
    import mat_stream_port_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          unload_req,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_success,
    input  logic          sys_fail,
    output logic          busy,
    output logic          result_ok,
    output logic          result_fail
);

    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] pop_cnt_q, pop_cnt_d;
    logic          rd_inflight_q;
    logic          wr_en_q, start_q, ok_q, fail_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [1:0]    fifo_occ;
    logic [2:0]    reads_pending;
    logic          s_hs, pop;

    assign s_ready = (state_q == StLoad);
    assign s_hs    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign busy    = (state_q != StIdle);

    // A word leaving the FIFO this cycle frees its slot, which sustains one read per cycle.
    assign reads_pending = {1'b0, fifo_occ} + {2'b0, rd_inflight_q} - {2'b0, pop};
    assign mem_rd_en     = (state_q == StUnload) && (rd_cnt_q < DepthCnt) &&
                           (reads_pending < 3'd2);
    assign mem_rd_addr   = rd_cnt_q[AW-1:0];

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign sys_start   = start_q;
    assign result_ok   = ok_q;
    assign result_fail = fail_q;

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        pop_cnt_d = pop_cnt_q;
        case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d  = StLoad;
                    wr_cnt_d = '0;
                end else if (unload_req) begin
                    state_d   = StUnload;
                    rd_cnt_d  = '0;
                    pop_cnt_d = '0;
                end
            end
            StLoad: begin
                if (s_hs) begin
                    wr_cnt_d = wr_cnt_q + AW'(1);
                    if (wr_cnt_q == LastIdx) state_d = StKick;
                end
            end
            StKick: state_d = StWait;
            StWait: if (sys_done) state_d = StIdle;
            StUnload: begin
                if (mem_rd_en) rd_cnt_d = rd_cnt_q + (AW+1)'(1);
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + AW'(1);
                    if (pop_cnt_q == LastIdx) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            pop_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            start_q       <= 1'b0;
            ok_q          <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            rd_inflight_q <= mem_rd_en;
            wr_en_q       <= s_hs;
            if (s_hs) begin
                wr_addr_q <= wr_cnt_q;
                wr_data_q <= s_data;
            end
            // Start pulse lands one cycle after the final memory write.
            start_q <= (state_q == StKick);
            if (state_q == StIdle && load_req) begin
                ok_q   <= 1'b0;
                fail_q <= 1'b0;
            end else if (state_q == StWait && sys_done) begin
                ok_q   <= sys_success;
                fail_q <= sys_fail;
            end
        end
    end

    stream_skid_fifo #(
        .DW (DW)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight_q),
        .push_data (mem_rd_data),
        .pop       (m_ready),
        .valid     (m_valid),
        .head      (m_data),
        .occupancy (fifo_occ)
    );

endmodule

// File: tb/tb_mat_stream_port.sv
// Randomized scoreboard bench for mat_stream_port with a behavioural memory and transfer model.
module tb_mat_stream_port;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_req = 1'b0, unload_req = 1'b0;
    logic          s_valid = 1'b0, s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid, m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          sys_start, sys_done = 1'b0, sys_success = 1'b0, sys_fail = 1'b0;
    logic          busy, result_ok, result_fail;

    always #5 clk = ~clk;

    mat_stream_port #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .unload_req  (unload_req),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .sys_start   (sys_start),
        .sys_done    (sys_done),
        .sys_success (sys_success),
        .sys_fail    (sys_fail),
        .busy        (busy),
        .result_ok   (result_ok),
        .result_fail (result_fail)
    );

    // Environment memory (written by the DUT) and the bench's own record of intended contents.
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_exp_q[$];
    logic [DW-1:0] out_exp_q[$];
    wr_t           mon_e;
    logic [DW-1:0] mon_w;

    int vectors = 0, miscompares = 0;
    int cyc = 0, rd_en_cnt = 0, start_cnt = 0, start_cyc = -1;
    int first_wr_cyc = -1, last_wr_cyc = -1, first_valid_cyc = -1;
    bit hold_pending = 1'b0, idle_check = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a write or an output word.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_pending = 1'b0;
            idle_check   = 1'b0;
        end else begin
            if (idle_check) begin
                idle_check = 1'b0;
                check("idle_after_last_pop", busy, 1'b0);
            end
            if (hold_pending) begin
                check("hold_m_valid", m_valid, 1'b1);
                check("hold_m_data", m_data, hold_data);
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            if (mem_wr_en || mem_rd_en) check("wr_rd_exclusive", mem_wr_en & mem_rd_en, 1'b0);
            if (mem_rd_en) rd_en_cnt++;
            if (sys_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (mem_wr_en) begin
                if (mem_wr_addr == '0) first_wr_cyc = cyc;
                if (mem_wr_addr == AW'(DEPTH - 1)) last_wr_cyc = cyc;
                if (wr_exp_q.size() == 0) begin
                    check("unexpected_write", mem_wr_en, 1'b0);
                end else begin
                    mon_e = wr_exp_q.pop_front();
                    check("mem_wr_addr", mem_wr_addr, mon_e.addr);
                    check("mem_wr_data", mem_wr_data, mon_e.data);
                end
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (out_exp_q.size() == 0) begin
                    check("unexpected_word", m_valid, 1'b0);
                end else begin
                    mon_w = out_exp_q.pop_front();
                    check("m_data", m_data, mon_w);
                    if (out_exp_q.size() == 0) idle_check = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        wr_exp_q.delete();
        out_exp_q.delete();
        check("rst_flags", {s_ready, m_valid, mem_wr_en, mem_rd_en, sys_start, busy,
                            result_ok, result_fail}, 8'h00);
        check("rst_wr_addr_data", {mem_wr_addr, mem_wr_data}, '0);
        check("rst_rd_addr", mem_rd_addr, '0);
        check("rst_m_data", m_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_load(input int n, input bit gaps, input bit rnd_data, input bit both);
        logic [DW-1:0] d;
        bit ok;
        load_req   = 1'b1;
        unload_req = both;
        tick();
        load_req   = 1'b0;
        unload_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = rnd_data ? DW'($urandom) : DW'(i);
            ref_mem[i] = d;
            wr_exp_q.push_back({AW'(i), d});
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = d;
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) check("s_ready_timeout", ok, 1'b1);
        end
        s_valid = 1'b0;
    endtask

    task automatic post_load(input int start_before, input bit consec);
        repeat (4) tick();
        check("sys_start_count", start_cnt - start_before, 1);
        check("sys_start_after_last_wr", start_cyc - last_wr_cyc, 1);
        if (consec) check("writes_consecutive", last_wr_cyc - first_wr_cyc, DEPTH - 1);
        check("busy_in_wait", busy, 1'b1);
    endtask

    task automatic wait_phase(input bit succ, input bit fl);
        int rd_before;
        rd_before   = rd_en_cnt;
        // Result inputs without done, and an unload request, must both be ignored.
        sys_success = 1'b1;
        sys_fail    = 1'b1;
        unload_req  = 1'b1;
        tick();
        unload_req  = 1'b0;
        repeat (3) tick();
        check("done_low_ignored", {result_ok, result_fail}, 2'b00);
        check("unload_in_wait_ignored", rd_en_cnt - rd_before, 0);
        sys_done    = 1'b1;
        sys_success = succ;
        sys_fail    = fl;
        tick();
        sys_done    = 1'b0;
        sys_success = 1'b0;
        sys_fail    = 1'b0;
        @(negedge clk);
        check("result_ok", result_ok, succ);
        check("result_fail", result_fail, fl);
        check("busy_after_done", busy, 1'b0);
        tick();
    endtask

    task automatic do_unload(input bit rnd_ready);
        int req_cyc;
        for (int i = 0; i < DEPTH; i++) out_exp_q.push_back(ref_mem[i]);
        first_valid_cyc = -1;
        m_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        unload_req = 1'b1;
        tick();
        req_cyc    = cyc;
        unload_req = 1'b0;
        for (int t = 0; t < 600 && out_exp_q.size() != 0; t++) begin
            tick();
            if (rnd_ready) m_ready = ($urandom_range(0, 9) < 6);
        end
        check("unload_complete", out_exp_q.size(), 0);
        // m_valid rises at the second edge after the sampling edge, seen at the next negedge.
        if (!rnd_ready) check("first_valid_latency", first_valid_cyc - req_cyc, 3);
        repeat (2) tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int s0, rd0;
        bit succ;
        #2;
        pulse_reset();

        // Sequential data, s_valid held high.
        s0 = start_cnt;
        do_load(DEPTH, 1'b0, 1'b0, 1'b0);
        post_load(s0, 1'b1);
        wait_phase(1'b1, 1'b0);

        // Gapped s_valid, random data.
        s0 = start_cnt;
        do_load(DEPTH, 1'b1, 1'b1, 1'b0);
        post_load(s0, 1'b0);
        wait_phase(1'b1, 1'b0);
        check("result_ok_sticky_idle", result_ok, 1'b1);

        // Unload from a preset pattern, then with random backpressure.
        for (int x = 0; x < DEPTH; x++) begin
            mem[x]     = DW'(x) ^ 8'hA5;
            ref_mem[x] = 8'hA5 ^ DW'(x);
        end
        do_unload(1'b0);
        check("result_ok_kept_over_unload", result_ok, 1'b1);
        do_unload(1'b1);

        // Simultaneous requests: load wins.
        rd0 = rd_en_cnt;
        s0  = start_cnt;
        do_load(DEPTH, 1'b0, 1'b1, 1'b1);
        check("both_req_no_read", rd_en_cnt - rd0, 0);
        post_load(s0, 1'b1);
        wait_phase(1'b0, 1'b1);
        do_unload(1'b0);

        // Reset after 10 words, then a full load must restart at address 0.
        do_load(10, 1'b0, 1'b1, 1'b0);
        pulse_reset();
        s0 = start_cnt;
        do_load(DEPTH, 1'b1, 1'b1, 1'b0);
        post_load(s0, 1'b0);
        wait_phase(1'b1, 1'b0);

        // Reset mid-unload, then a full unload restarts from address 0.
        for (int i = 0; i < DEPTH; i++) out_exp_q.push_back(ref_mem[i]);
        m_ready    = 1'b1;
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
        repeat (6) tick();
        pulse_reset();
        m_ready = 1'b0;
        do_unload(1'b1);

        for (int r = 0; r < 3; r++) begin
            succ = 1'($urandom_range(0, 1));
            s0   = start_cnt;
            do_load(DEPTH, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            post_load(s0, 1'b0);
            wait_phase(succ, ~succ);
            do_unload(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
